// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package shift_add_mult_pkg;

  // Sequencer states; 3-bit encoding leaves one spare code that recovers to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    TEST  = 3'd3,
    ADD   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Cycles spent before the first TEST (CLEAR + LOAD) and in DONE.
  localparam int SETUP_CYCLES = 2;
  localparam int DONE_CYCLES  = 1;

  // Iteration counter width: holds 0..WIDTH-1 with one bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter: cleared at operand load, advanced once per shift,
// flags the last iteration. Saturates at WIDTH-1 so it never wraps.
module mult_iter_cnt #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Next count: clear wins, otherwise step until the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Start/done sequencer for the shift-add multiplier datapath.
// Runs WIDTH test/add/shift iterations, adding only when the multiplier LSB is 1.
// Optional macro SHIFT_ADD_MULT_EARLY_TERM_EN: finish as soon as the multiplier
// register reads zero in TEST (product then left unaligned by the skipped shifts).
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic b_lsb,
  input  logic b_zero,
  output logic busy,
  output logic done,
  output logic clr,
  output logic ld,
  output logic ldp,
  output logic shp,
  output logic shb
);

  localparam int CW = cnt_width(WIDTH);

  state_e state_q;
  state_e state_d;
  logic   iter_last;

`ifndef SHIFT_ADD_MULT_EARLY_TERM_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  mult_iter_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == LOAD),
    .enable (state_q == SHIFT),
    .last   (iter_last)
  );

  // Next-state logic; b_lsb/b_zero are only looked at in TEST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    state_d = TEST;
      TEST: begin
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        if (b_zero)     state_d = DONE;
        else if (b_lsb) state_d = ADD;
        else            state_d = SHIFT;
`else
        if (b_lsb) state_d = ADD;
        else       state_d = SHIFT;
`endif
      end
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = iter_last ? DONE : TEST;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, forced to IDLE immediately by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    clr  = 1'b0;
    ld   = 1'b0;
    ldp  = 1'b0;
    shp  = 1'b0;
    shb  = 1'b0;
    case (state_q)
      CLEAR: begin busy = 1'b1; clr = 1'b1; end
      LOAD:  begin busy = 1'b1; ld  = 1'b1; end
      TEST:  begin busy = 1'b1; end
      ADD:   begin busy = 1'b1; ldp = 1'b1; end
      SHIFT: begin busy = 1'b1; shp = 1'b1; shb = 1'b1; end
      DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule
